// File: rtl/if_stage.sv
// Instruction fetch stage: PC, fetch FSM, skid buffer, IF/ID register.
// Handles stall, flush, jump/branch redirect and late-response discard.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] pcbranch,
  input  logic        jump,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_id,
  output logic [31:0] pcplus4_id,
  output logic        valid_id
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD,
    HOLD
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } skid_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] disc_addr, disc_nx;
  if_id_t      ifid, ifid_nx;
  skid_t       skid, skid_nx;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc4;

  assign pc4      = pc + 32'd4;
  assign redirect = ifid.valid & ~stall
                  & (jump | branch_taken);
  assign target   = jump
    ? {ifid.pcplus4[31:28], ifid.instr[25:0], 2'b00}
    : pcbranch;

  assign imem_req  = (state == FETCH)
                   | (state == DISCARD);
  assign imem_addr = (state == DISCARD)
                   ? disc_addr : pc;

  assign instr_id   = ifid.instr;
  assign pcplus4_id = ifid.pcplus4;
  assign valid_id   = ifid.valid;

  // State, PC, skid and IF/ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      disc_addr <= '0;
      ifid      <= '0;
      skid      <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      disc_addr <= disc_nx;
      ifid      <= ifid_nx;
      skid      <= skid_nx;
    end
  end

  // Next-state, PC and pipeline-register update
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    disc_nx  = disc_addr;
    ifid_nx  = ifid;
    skid_nx  = skid;
    unique case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        if (!stall) ifid_nx = '0;
        if (redirect) begin
          pc_nx = target;
          if (!imem_ready) begin
            state_nx = DISCARD;
            disc_nx  = pc;
          end
        end else if (imem_ready) begin
          pc_nx = pc4;
          if (stall) begin
            skid_nx  = '{instr: imem_rdata,
                         pcplus4: pc4};
            state_nx = HOLD;
          end else begin
            ifid_nx = '{instr: imem_rdata,
                        pcplus4: pc4,
                        valid: 1'b1};
          end
        end
      end
      DISCARD: begin
        if (!stall) ifid_nx = '0;
        if (redirect) pc_nx = target;
        if (imem_ready) state_nx = FETCH;
      end
      HOLD: begin
        if (redirect) begin
          pc_nx    = target;
          ifid_nx  = '0;
          skid_nx  = '0;
          state_nx = FETCH;
        end else if (flush) begin
          skid_nx  = '0;
          state_nx = FETCH;
        end else if (!stall) begin
          ifid_nx  = '{instr: skid.instr,
                       pcplus4: skid.pcplus4,
                       valid: 1'b1};
          skid_nx  = '0;
          state_nx = FETCH;
        end
      end
    endcase
    if (flush) ifid_nx = '0;
  end

endmodule
